// File: rtl/serial_deserializer_4bit.sv
// Serial-to-parallel receiver for 4-bit frames: start 0, four data bits, stop 1.
// Bit order is chosen per frame by Dir, which is sampled together with the start bit.
module serial_deserializer_4bit (
    input  logic       CLK,
    input  logic       Clear,
    input  logic       Serial_in,
    input  logic       Dir,
    output logic [3:0] D_par,
    output logic       Valid,
    output logic       Frame_err,
    output logic       Busy
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StData  = 2'b01,
        StStop  = 2'b10,
        StBreak = 2'b11
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] sh_q, sh_d;
    logic [1:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;
    logic [3:0] d_par_q, d_par_d;
    logic       valid_q, valid_d;
    logic       frame_err_q, frame_err_d;

    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            state_q     <= StIdle;
            sh_q        <= 4'b0000;
            cnt_q       <= 2'd0;
            dir_q       <= 1'b0;
            d_par_q     <= 4'b0000;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            d_par_q     <= d_par_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        d_par_d     = d_par_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (!Serial_in) begin
                    state_d = StData;
                    cnt_d   = 2'd0;
                    dir_d   = Dir;
                end
            end
            StData: begin
                // dir_q=0: LSB-first, bits enter at the top; dir_q=1: MSB-first, enter at bottom
                if (dir_q) begin
                    sh_d = {sh_q[2:0], Serial_in};
                end else begin
                    sh_d = {Serial_in, sh_q[3:1]};
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (Serial_in) begin
                    d_par_d = sh_q;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = StBreak;
                end
            end
            StBreak: begin
                // A line stuck low must return high before a new start bit is honoured
                if (Serial_in) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign D_par     = d_par_q;
    assign Valid     = valid_q;
    assign Frame_err = frame_err_q;
    assign Busy      = (state_q != StIdle);

endmodule

// File: doc/serial_deserializer_4bit.md
SERIAL_DESERIALIZER_4BIT -- requirements
Module: serial_deserializer_4bit

Interface
REQ-001 The block SHALL have a port `CLK`: input, 1 bit, the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have a port `Clear`: input, 1 bit, asynchronous active-high reset.
REQ-003 The block SHALL have a port `Serial_in`: input, 1 bit, serial line from a 4-bit shift-register transmitter, one bit per CLK; idles high.
REQ-004 The block SHALL have a port `Dir`: input, 1 bit. 0 = LSB-first: each bit enters at bit 3 and the word shifts right. 1 = MSB-first: each bit enters at bit 0 and the word shifts left.
REQ-005 The block SHALL have a port `D_par`: output, 4 bits, last correctly framed word (registered).
REQ-006 The block SHALL have a port `Valid`: output, 1 bit, one-cycle pulse when D_par is updated.
REQ-007 The block SHALL have a port `Frame_err`: output, 1 bit, one-cycle pulse on a bad stop bit.
REQ-008 The block SHALL have a port `Busy`: output, 1 bit, high whenever the state is not IDLE.

Function
REQ-009 The frame format SHALL be: start bit 0, then 4 data bits, then stop bit 1; Serial_in is sampled once per rising edge.
REQ-010 The FSM SHALL have four states: IDLE, DATA, STOP, BREAK; encoding is free.
REQ-011 In IDLE, sampling Serial_in=0 SHALL move the FSM to DATA, clear the bit counter to 0, and latch Dir into an internal dir_q for the whole frame.
REQ-012 In IDLE, Serial_in=1 SHALL keep the FSM in IDLE.
REQ-013 Changes of Dir after the start edge SHALL be ignored until the next start bit.
REQ-014 In DATA, each edge SHALL shift Serial_in into a 4-bit internal shift register and increment a 2-bit counter. dir_q=0 gives sh <= {Serial_in, sh[3:1]}; dir_q=1 gives sh <= {sh[2:0], Serial_in}.
REQ-015 On the edge that captures the 4th data bit (counter==3), the FSM SHALL move to STOP.
REQ-016 In STOP, Serial_in=1 SHALL load D_par <= sh, assert Valid for exactly that following cycle, and return the FSM to IDLE.
REQ-017 In STOP, Serial_in=0 SHALL leave D_par unchanged, pulse Frame_err for one cycle, and move the FSM to BREAK.
REQ-018 In BREAK, the FSM SHALL remain until Serial_in=1 is sampled, then go to IDLE. A line held low SHALL never start a new frame.
REQ-019 Latency: with the start bit sampled at edge k, data SHALL be sampled at edges k+1..k+4, stop at k+5, and D_par/Valid SHALL be updated by edge k+5.
REQ-020 Back-to-back frames SHALL be supported: the next start bit may be sampled at edge k+6 with no gap cycle lost.
REQ-021 Valid and Frame_err SHALL never be high in the same cycle, and each SHALL be high for at most one cycle per frame.
REQ-022 Busy SHALL be a decode of the registered state, high from the cycle after the start edge until the return to IDLE.
REQ-023 D_par SHALL hold its value indefinitely between valid frames; it SHALL NOT change during DATA, BREAK or on an error.

Reset
REQ-024 Clear=1 SHALL immediately, without waiting for CLK, force state=IDLE, sh=0000, counter=0, dir_q=0, D_par=0000, Valid=0, Frame_err=0, Busy=0.
REQ-025 Clear asserted mid-frame (DATA or STOP) SHALL abort the frame: no Valid and no Frame_err for the aborted frame.
REQ-026 After Clear deasserts, the first start bit sampled at a rising edge SHALL begin a new frame normally.

Verification
REQ-027 Scenario, LSB-first: Dir=0; drive line 1,1,0,0,1,0,1,1 (start, data 0,1,0,1, stop) -> D_par=1010, Valid high for one cycle at stop edge+0, Busy high for 5 cycles.
REQ-028 Scenario, MSB-first: Dir=1; drive start 0, data 1,0,1,0, stop 1 -> D_par=1010, Valid one pulse; then Dir=1 with data 0,1,1,1 -> D_par=0111.
REQ-029 Scenario, framing error: Dir=0, data 1,1,1,1, stop 0, line held 0 for 3 more cycles, then 1 -> Frame_err one pulse, D_par keeps its prior value, no new frame starts until the line returns high, then IDLE.
REQ-030 Scenario, back-to-back: two frames with no idle bit between (stop of frame 1 immediately followed by start of frame 2; data 1100 then 0011, Dir=0) -> two Valid pulses 6 cycles apart, D_par=0011 then 1100 per bit order check.
REQ-031 Scenario, reset mid-frame: assert Clear between CLK edges after 2 data bits -> all outputs 0 immediately; a following complete frame with data 0,1,1,0 and Dir=0 -> D_par=0110.
REQ-032 Scenario, Dir toggle mid-frame: start with Dir=1, flip Dir to 0 after the first data bit, data 1,0,0,0 -> D_par=1000, because the MSB-first order latched at the start bit is kept.
